// File: rtl/scaler_out_timing.sv
// Output timing regenerator: buffers the bursty scaler pixel stream in a FIFO
// and replays it against a free-running raster (hs/vs/de) once a frame is aligned.
module scaler_out_timing #(
  parameter int                    DATA_WIDTH = 24,
  parameter int                    H_ACTIVE   = 1280,
  parameter int                    H_FP       = 110,
  parameter int                    H_SYNC     = 40,
  parameter int                    H_BP       = 220,
  parameter int                    V_ACTIVE   = 720,
  parameter int                    V_FP       = 5,
  parameter int                    V_SYNC     = 5,
  parameter int                    V_BP       = 20,
  parameter int                    FIFO_DEPTH = 2048,
  parameter int                    PREFILL    = 1280,
  parameter bit                    SYNC_POL   = 1'b1,
  parameter logic [DATA_WIDTH-1:0] BLANK_DATA = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          in_vs,
  input  logic                          in_de,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          out_hs,
  output logic                          out_vs,
  output logic                          out_de,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          locked,
  output logic                          underflow,
  output logic                          overflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int LW      = AW + 1;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [LW-1:0] PRE_L   = LW'(PREFILL);
  localparam logic [LW-1:0] FULL_L  = LW'(FIFO_DEPTH);

  typedef enum logic {S_WAIT = 1'b0, S_RUN = 1'b1} state_t;

  logic [HW-1:0]         r_h;
  logic [VW-1:0]         r_v;
  logic                  r_vs_d;
  state_t                r_state;
  logic                  r_bad;
  logic                  r_uf, r_of;
  logic [AW-1:0]         r_wp, r_rp;
  logic [LW-1:0]         r_level;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

  logic w_h_last, w_v_last, w_eof, w_active, w_hs_on, w_vs_on;
  logic w_vs_rise, w_flush, w_empty, w_full, w_rd_act, w_rd, w_wr;

  assign w_h_last = (r_h == H_LAST);
  assign w_v_last = (r_v == V_LAST);
  assign w_eof    = w_h_last & w_v_last;
  assign w_active = (r_h < H_ACT) & (r_v < V_ACT);
  assign w_hs_on  = (r_h >= HS_BEG) & (r_h < HS_END);
  assign w_vs_on  = (r_v >= VS_BEG) & (r_v < VS_END);

  // A new scaler frame, or being disabled while unlocked, discards buffered pixels.
  assign w_vs_rise = in_vs & ~r_vs_d;
  assign w_flush   = w_vs_rise | (~en & (r_state == S_WAIT));
  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == FULL_L);
  assign w_rd_act  = (r_state == S_RUN) & w_active & ~w_flush;
  assign w_rd      = w_rd_act & ~w_empty;
  assign w_wr      = in_de & en & ~w_full & ~w_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_last) begin
      r_h <= '0;
      r_v <= w_v_last ? '0 : r_v + VW'(1);
    end else begin
      r_h <= r_h + HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else if (w_flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_rd) r_rp <= r_rp + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs_d <= 1'b0;
      r_uf   <= 1'b0;
      r_of   <= 1'b0;
    end else begin
      r_vs_d <= in_vs;
      if (w_vs_rise) begin
        r_uf <= 1'b0;
        r_of <= 1'b0;
      end else begin
        if (in_de & en & w_full & ~w_flush) r_of <= 1'b1;
        if (w_rd_act & w_empty)             r_uf <= 1'b1;
      end
    end
  end

  // Lock only on the last clock of a frame so the first RUN pixel lands on (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_WAIT;
      r_bad   <= 1'b0;
    end else if (w_flush) begin
      r_state <= S_WAIT;
      r_bad   <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (w_eof && en && (r_level >= PRE_L)) r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_rd_act && w_empty) r_bad <= 1'b1;
          if (w_eof) begin
            if (r_bad || !en) r_state <= S_WAIT;
            r_bad <= 1'b0;
          end
        end
        default: r_state <= S_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_hs   <= ~SYNC_POL;
      out_vs   <= ~SYNC_POL;
      out_de   <= 1'b0;
      out_data <= BLANK_DATA;
    end else begin
      out_hs   <= w_hs_on ? SYNC_POL : ~SYNC_POL;
      out_vs   <= w_vs_on ? SYNC_POL : ~SYNC_POL;
      out_de   <= w_active;
      out_data <= w_rd ? r_mem[r_rp] : BLANK_DATA;
    end
  end

  assign fifo_level = r_level;
  assign locked     = (r_state == S_RUN);
  assign underflow  = r_uf;
  assign overflow   = r_of;

endmodule

// File: tb/tb_scaler_out_timing.sv
// Bench for scaler_out_timing on a tiny 14x7 raster: raster table, directed
// lock/underflow/overflow/reset sequences, and random traffic against a queue model.
module tb_scaler_out_timing;
  localparam int DW = 24, HA = 8, HFP = 2, HSY = 2, HBP = 2;
  localparam int VA = 4, VFP = 1, VSY = 1, VBP = 1, DEPTH = 16, PRE = 8;
  localparam int HT = HA + HFP + HSY + HBP, VT = VA + VFP + VSY + VBP;
  localparam bit POL = 1'b1;
  localparam logic [DW-1:0] BLANK = 24'h000000;

  logic clk = 1'b0, rst = 1'b1, en = 1'b0, in_vs = 1'b0, in_de = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic out_hs, out_vs, out_de, locked, underflow, overflow;
  logic [DW-1:0] out_data;
  logic [4:0] fifo_level;

  scaler_out_timing #(
    .DATA_WIDTH(DW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .FIFO_DEPTH(DEPTH), .PREFILL(PRE), .SYNC_POL(POL), .BLANK_DATA(BLANK)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .in_vs(in_vs), .in_de(in_de), .in_data(in_data),
    .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de), .out_data(out_data),
    .fifo_level(fifo_level), .locked(locked), .underflow(underflow), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference model: raster position from a frame-relative clock count, FIFO as a queue.
  int m_t, cyc;
  bit m_run, m_bad, m_uf, m_of, m_pvs;
  logic [DW-1:0] m_q[$];
  logic e_hs, e_vs, e_de;
  logic [DW-1:0] e_data;

  task automatic model_step();
    int h, v, sz;
    bit act, eof, rise, flush;
    h = m_t % HT;
    v = m_t / HT;
    act = (h < HA) && (v < VA);
    eof = (h == HT - 1) && (v == VT - 1);
    rise = in_vs && !m_pvs;
    flush = rise || (!en && !m_run);
    sz = m_q.size();
    e_de = act;
    e_hs = (h >= HA + HFP && h < HA + HFP + HSY) ? POL : !POL;
    e_vs = (v >= VA + VFP && v < VA + VFP + VSY) ? POL : !POL;
    e_data = BLANK;
    if (rise) begin m_uf = 0; m_of = 0; end
    if (flush) begin
      m_q.delete();
      m_run = 0;
      m_bad = 0;
    end else begin
      if (m_run && act) begin
        if (sz == 0) begin m_uf = 1; m_bad = 1; end
        else e_data = m_q.pop_front();
      end
      if (in_de && en) begin
        if (sz == DEPTH) m_of = 1;
        else m_q.push_back(in_data);
      end
      if (eof) begin
        if (!m_run) m_run = (sz >= PRE) && en;
        else begin
          if (m_bad || !en) m_run = 0;
          m_bad = 0;
        end
      end
    end
    m_pvs = in_vs;
    m_t = (m_t + 1) % (HT * VT);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_t = 0; cyc = 0;
      m_run = 0; m_bad = 0; m_uf = 0; m_of = 0; m_pvs = 0;
      m_q.delete();
      e_hs = !POL; e_vs = !POL; e_de = 0; e_data = BLANK;
    end else begin
      cyc++;
      model_step();
    end
    #1;
    chk("cycle_model",
        64'({out_hs, out_vs, out_de, out_data, fifo_level, locked, underflow, overflow}),
        64'({e_hs, e_vs, e_de, e_data, 5'(m_q.size()), m_run, m_uf, m_of}));
  end

  typedef struct { int c; logic de; logic hs; logic vs; } tv_t;
  tv_t tbl[14];
  logic [DW-1:0] got[64];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, n, nxt;
    bit seen, fell, hit;
    int pct[6];
    tbl[0]  = '{1, 1, 0, 0};   tbl[1]  = '{8, 1, 0, 0};   tbl[2]  = '{9, 0, 0, 0};
    tbl[3]  = '{11, 0, 1, 0};  tbl[4]  = '{12, 0, 1, 0};  tbl[5]  = '{13, 0, 0, 0};
    tbl[6]  = '{15, 1, 0, 0};  tbl[7]  = '{43, 1, 0, 0};  tbl[8]  = '{57, 0, 0, 0};
    tbl[9]  = '{71, 0, 0, 1};  tbl[10] = '{84, 0, 0, 1};  tbl[11] = '{85, 0, 0, 0};
    tbl[12] = '{99, 1, 0, 0};  tbl[13] = '{109, 0, 1, 0};
    pct = '{15, 30, 33, 50, 90, 40};

    @(posedge clk); #1;
    chk("reset_state",
        64'({out_hs, out_vs, out_de, out_data, fifo_level, locked, underflow, overflow}),
        64'({!POL, !POL, 1'b0, BLANK, 5'd0, 3'b000}));
    @(negedge clk); rst = 0;

    // Free-running raster with en=0 and no input.
    idx = 0;
    for (int k = 1; k <= 110; k++) begin
      @(posedge clk); #1;
      if (idx < 14 && cyc == tbl[idx].c) begin
        chk($sformatf("freerun_edge%0d", tbl[idx].c),
            64'({out_de, out_hs, out_vs, out_data}),
            64'({tbl[idx].de, tbl[idx].hs, tbl[idx].vs, BLANK}));
        idx++;
      end
    end
    chk("freerun_table_done", 64'(idx), 64'(14));

    // Lock on pixels 1..32, then a 20-pixel frame that must underflow.
    @(negedge clk); en = 1; in_vs = 1;
    @(negedge clk); @(negedge clk); in_vs = 0;
    nxt = 1; n = 0; seen = 0; fell = 0;
    for (int k = 0; k < 800 && !fell; k++) begin
      @(posedge clk); #1;
      if (seen && out_de && n < 64) begin
        got[n] = out_data;
        n++;
        if (n == 32) begin
          chk("no_underflow_frame1", 64'(underflow), 64'(0));
          chk("locked_frame1", 64'(locked), 64'(1));
        end
      end
      if (locked) seen = 1;
      if (seen && n == 64 && !locked) fell = 1;
      @(negedge clk);
      if (nxt <= 52 && int'(fifo_level) < 14) begin
        in_de = 1; in_data = DW'(nxt); nxt++;
      end else in_de = 0;
    end
    in_de = 0;
    chk("lock_seen", 64'(seen), 64'(1));
    chk("unlock_after_bad_frame", 64'(fell), 64'(1));
    chk("underflow_sticky", 64'(underflow), 64'(1));
    chk("pixels_collected", 64'(n), 64'(64));
    for (int i = 0; i < n; i++)
      chk($sformatf("pixel%0d", i), 64'(got[i]), (i < 52) ? 64'(i + 1) : 64'(BLANK));

    // Lock again, then hit an asynchronous reset at h=5, v=2.
    @(negedge clk); in_vs = 1;
    @(negedge clk); in_vs = 0;
    nxt = 100; hit = 0;
    for (int k = 0; k < 600; k++) begin
      if (locked && m_t == 33) begin hit = 1; break; end
      if (int'(fifo_level) < 14) begin in_de = 1; in_data = DW'(nxt); nxt++; end
      else in_de = 0;
      @(negedge clk);
    end
    in_de = 0;
    chk("midframe_reached", 64'(hit), 64'(1));
    chk("de_high_before_reset", 64'(out_de), 64'(1));
    rst = 1; #1;
    chk("async_reset_outputs",
        64'({out_hs, out_vs, out_de, out_data, fifo_level, locked, underflow, overflow}),
        64'({!POL, !POL, 1'b0, BLANK, 5'd0, 3'b000}));
    @(negedge clk); @(negedge clk); rst = 0;
    @(posedge clk); #1;
    chk("de_after_release", 64'(out_de), 64'(1));
    chk("unlocked_after_release", 64'(locked), 64'(0));

    // Overflow in WAIT_SYNC, then clear by an in_vs rising edge.
    @(negedge clk); in_vs = 1;
    @(negedge clk); in_vs = 0;
    repeat (20) begin
      in_de = 1; in_data = DW'($urandom);
      @(negedge clk);
    end
    #1;
    chk("level_saturated", 64'(fifo_level), 64'(16));
    chk("overflow_set", 64'(overflow), 64'(1));
    in_de = 0; in_vs = 1;
    @(posedge clk); #1;
    chk("level_after_flush", 64'(fifo_level), 64'(0));
    chk("overflow_cleared", 64'(overflow), 64'(0));

    // Write then simultaneous write+flush.
    @(negedge clk); in_vs = 0; in_de = 1; in_data = 24'hABCDEF;
    @(posedge clk); #1;
    chk("write_before_flush", 64'(fifo_level), 64'(1));
    @(negedge clk); in_vs = 1; in_de = 1;
    @(posedge clk); #1;
    chk("flush_beats_write", 64'(fifo_level), 64'(0));
    @(negedge clk); in_vs = 0; in_de = 0;

    // Random traffic against the model.
    for (int s = 0; s < 6; s++) begin
      for (int k = 0; k < 500; k++) begin
        @(negedge clk);
        if ($urandom_range(0, 199) == 0) en = !en;
        in_de = ($urandom_range(0, 99) < pct[s]);
        in_data = DW'($urandom);
        if (in_vs) in_vs = ($urandom_range(0, 2) != 0);
        else in_vs = ($urandom_range(0, 299) == 0);
      end
    end
    @(negedge clk); in_de = 0; in_vs = 0;
    @(posedge clk); #2;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/scaler_out_timing.md
Name: scaler_out_timing

Overview:
- Output end of the scaler path: takes the bursty pixel stream emitted by the scaler (`in_vs` / `in_de` / `in_data`) and regenerates clean, free-running raster timing (`hs` / `vs` / `de`) for the display encoder.
- Buffers pixels in an internal FIFO and paces them out at exactly one pixel per active clock.
- Runs entirely in the scaler output clock domain.
- Detects frame alignment, underflow and overflow.

Parameters:
- DATA_WIDTH, 24, pixel width.
- H_ACTIVE, 1280, active pixels per line.
- H_FP, 110, horizontal front porch, in clocks.
- H_SYNC, 40, hsync width, in clocks.
- H_BP, 220, horizontal back porch, in clocks.
- V_ACTIVE, 720, active lines.
- V_FP, 5, vertical front porch, in lines.
- V_SYNC, 5, vsync width, in lines.
- V_BP, 20, vertical back porch, in lines.
- FIFO_DEPTH, 2048, pixel FIFO entries; must be a power of 2 and at least PREFILL+1.
- PREFILL, 1280, FIFO level required before output is released.
- SYNC_POL, 1, hs/vs active level; 1 = active-high.
- BLANK_DATA, 24'h000000, pixel driven on underflow and during blanking.

Ports:
- clk, in, 1, pixel clock (scaler output clock).
- rst, in, 1, asynchronous active-high reset.
- en, in, 1, 0 = hold in WAIT_SYNC with the FIFO flushed; timing keeps running.
- in_vs, in, 1, frame marker from the scaler; high between frames.
- in_de, in, 1, input pixel valid.
- in_data, in, DATA_WIDTH, input pixel.
- out_hs, out, 1, horizontal sync.
- out_vs, out, 1, vertical sync.
- out_de, out, 1, active video.
- out_data, out, DATA_WIDTH, output pixel.
- fifo_level, out, log2(FIFO_DEPTH)+1, current FIFO occupancy.
- locked, out, 1, high while in RUN.
- underflow, out, 1, sticky; cleared by rst or an in_vs rising edge.
- overflow, out, 1, sticky; cleared by rst or an in_vs rising edge.

Behaviour:
- Reset values: all outputs and counters 0. out_hs and out_vs are at the inactive level (!SYNC_POL). out_data = BLANK_DATA. State = WAIT_SYNC.
- Timing counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - v_cnt increments when h_cnt wraps, and runs 0..V_TOTAL-1.
  - Both counters free-run from reset regardless of state.
- Regions, all outputs registered one clock after the counter value:
  - active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs active when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs active when v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), aligned to h_cnt=0.
  - out_de = active. This holds in every state, so the sink always sees a valid raster.
- FIFO:
  - Synchronous, single clock.
  - Write when in_de && !full && en; in_de while full drops the pixel and sets overflow.
  - in_vs rising edge: synchronous flush (pointers and level to 0), clears the sticky flags, and forces state to WAIT_SYNC.
  - Simultaneous write and flush: the flush wins and the pixel is discarded.
- State machine:
  - WAIT_SYNC:
    - out_data = BLANK_DATA; no reads.
    - Move to RUN on the clock where h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1, fifo_level >= PREFILL and en=1, so the first RUN pixel is pixel (0,0).
  - RUN:
    - On each active clock, read one pixel and present it on out_data with out_de (first-word-fall-through read, same registered stage).
    - If the FIFO is empty on an active clock: out_data = BLANK_DATA, set underflow, mark the frame bad.
    - At the end of frame (h_cnt=H_TOTAL-1, v_cnt=V_TOTAL-1): return to WAIT_SYNC if the frame was bad or en=0, otherwise stay in RUN.
  - locked = (state == RUN).
- Simultaneous FIFO read and write: level unchanged. Read of the last entry with a concurrent write is not an underflow.
- rst asserted mid-frame clears everything asynchronously. Timing restarts at (0,0) on the first clock after release.

Test Plan:
Small config for all scenarios: H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2 (H_TOTAL=14); V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=7); FIFO_DEPTH=16; PREFILL=8.
- Free-run timing: en=0, no input. Expect out_hs high for 2 clocks every 14 clocks, starting 10 clocks after de begins; out_vs high for 1 line out of every 7; out_de high for 8 clocks on lines 0-3; out_data = 0.
- Lock: pulse in_vs, then burst pixels 1..32 with en=1. Expect locked rising at a frame boundary. The first active line outputs 1..8 with out_de, contiguous; 32 pixels fill the frame exactly; underflow stays 0.
- Underflow: after lock, supply only 20 of the 32 pixels. Expect pixels 21-32 = BLANK_DATA, underflow=1, and locked falling at end of frame.
- Overflow: with en=1 in WAIT_SYNC, hold in_de high for 20 clocks. Expect fifo_level to saturate at 16 and overflow=1. After an in_vs rising edge, expect level=0 and overflow=0.
- Simultaneous flush and write: in_de and the in_vs rising edge in the same cycle. Expect fifo_level=0 on the next clock.
- Mid-frame reset: assert rst at h_cnt=5, v_cnt=2. Expect all outputs inactive immediately (asynchronous). After release, out_de rises 1 clock after the first clk edge, and locked=0.
